xbus_window_sched: RTL and testbench
====================================

Name: xbus_window_sched

Overview:
- Sequences the X-bus broadcast that feeds a row of NUM_COL convolution PEs for a 1-D sliding-window pass.
- Accepts an activation stream and broadcasts each word once, with a per-column enable mask. Column c accumulates output o_c, which needs inputs o_c..o_c+K-1.
- Retires finished columns, reassigns them to output o_c+NUM_COL, and stalls the stream while a needed column is still busy.
- Sits between the global buffer read port and the X bus / X_BusCtrl PE array.

Parameters:
DATA_WIDTH, 16, activation word width
NUM_COL, 3, number of PE columns on the X bus
IDX_W, 16, width of row-length and index counters

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous abort; same effect as reset, takes effect on the next edge
start  in  1  pulse; latches cfg when in IDLE, ignored otherwise
kernel_size  in  8  K, sampled on start
row_len  in  IDX_W  L, input words in row, sampled on start
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid&in_ready
in_data  in  DATA_WIDTH  input activation
pe_busy  in  NUM_COL  column c still draining previous result; cannot accept new window
x_valid  out  1  bus beat valid
x_data  out  DATA_WIDTH  broadcast word
x_col_en  out  NUM_COL  columns that must consume this beat
x_col_last  out  NUM_COL  beat is final (K-th) word for that column's output
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of row
cfg_err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset values: all outputs 0. State IDLE. in_idx=0. o_c=c.
- FSM states: IDLE, STREAM, DONE.
- IDLE: start with 1<=K<=NUM_COL and K<=L.
  - STREAM, in_idx=0, o_c=c, col_live[c]=(c<=L-K).
- IDLE: start otherwise.
  - cfg_err=1 for 1 cycle; stay IDLE.
- STREAM, per column:
  - en_c = col_live[c] && o_c<=in_idx && in_idx<o_c+K. Compare in IDX_W+1 bits, no wrap.
  - last_c = en_c && in_idx==o_c+K-1.
- STREAM, stall: stall = |(en & pe_busy). in_ready = (state==STREAM) && !stall. This is combinational from registers and pe_busy.
- On transfer, next cycle:
  - x_valid=1, x_data=in_data, x_col_en=en, x_col_last=last. Latency 1.
  - in_idx+1.
  - For each c with last_c: o_c += NUM_COL; col_live[c] = (o_c+NUM_COL <= L-K).
- No transfer: x_valid=0, x_col_en=0, x_col_last=0. x_data holds.
- Transfer of word L-1 moves STREAM to DONE. In DONE, done=1, coinciding with the final x_valid beat. Next cycle returns to IDLE.
- Every accepted word has a nonzero en mask. A column never receives more than K words per output.
- Cycle after a column's last beat: that column may be enabled for its next window, unless pe_busy stalls it. pe_busy on a non-enabled column has no effect.
- in_valid low in STREAM: idle cycles are allowed. Indices are unchanged.
- start while busy: ignored, no cfg_err.
- flush or rst mid-row: drop the row, x_valid=0 immediately (rst) or next edge (flush), return to IDLE. A simultaneous start on a flush cycle is ignored.
- Each output index 0..L-K is issued its K beats exactly once.

Test Plan:
- NUM_COL=3, K=3, L=5, pe_busy=0, continuous in_valid:
  - x_col_en = 001, 011, 111, 110, 100.
  - x_col_last = 000, 000, 001, 010, 100.
  - done pulses with beat 4; in_ready never drops.
- NUM_COL=3, K=2, L=6:
  - en = 001, 011, 110, 101, 011, 010.
  - last = 000, 001, 010, 100, 001, 010.
  - done with beat 5.
- K=2, L=6, pe_busy[0]=1 during word 3:
  - in_ready=0 while word 3 is pending.
  - Release after 4 cycles: word 3 issues with en=101; no beat is lost or duplicated.
- start with K=4, NUM_COL=3; then start with K=3, L=2:
  - cfg_err pulse each time, busy stays 0, x_valid stays 0.
- K=3, L=8, flush after beat 4:
  - busy=0 next cycle, x_valid=0.
  - A new start K=3, L=5 reproduces scenario 1 exactly.
- Assert rst asynchronously mid-beat:
  - x_valid, x_col_en, busy clear without a clock edge.
  - start is ignored while busy: with a start pulse at beat 2, the row still completes normally.

Source files
------------

// File: rtl/xbus_window_sched.sv
// X-bus broadcast sequencer for a 1-D sliding-window pass over NUM_COL PE columns.
// Each accepted word is broadcast once; every column accumulates one output window at a time.
module xbus_window_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 3,
    parameter int IDX_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  start,
    input  logic [7:0]            kernel_size,
    input  logic [IDX_W-1:0]      row_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [NUM_COL-1:0]    pe_busy,
    output logic                  x_valid,
    output logic [DATA_WIDTH-1:0] x_data,
    output logic [NUM_COL-1:0]    x_col_en,
    output logic [NUM_COL-1:0]    x_col_last,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    localparam int CW = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [IDX_W-1:0]        in_idx_reg;
    logic [IDX_W-1:0]        l_reg;
    logic [CW-1:0]           k_reg;
    logic [CW-1:0]           lmk_reg;
    logic                    x_valid_reg;
    logic [DATA_WIDTH-1:0]   x_data_reg;
    logic [NUM_COL-1:0]      x_col_en_reg;
    logic [NUM_COL-1:0]      x_col_last_reg;
    logic                    cfg_err_reg;

    logic [CW-1:0]           k_in, l_in, lmk_in, idx_ext;
    logic                    cfg_ok, start_ok, stall, xfer;
    logic [NUM_COL-1:0]      en, last;

    assign k_in     = CW'(kernel_size);
    assign l_in     = {1'b0, row_len};
    assign lmk_in   = l_in - k_in;
    assign idx_ext  = {1'b0, in_idx_reg};
    assign cfg_ok   = (kernel_size != 8'd0) && (k_in <= CW'(NUM_COL)) && (k_in <= l_in);
    assign start_ok = (state_reg == IDLE) && start && cfg_ok;

    // Windows are compared one bit wider than the counters so o_c+K never wraps.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_COL; gi++) begin : g_col
            logic [CW-1:0] o_reg;
            logic          live_reg;
            logic [CW-1:0] win_end;
            logic [CW-1:0] o_adv;

            assign win_end  = o_reg + k_reg;
            assign o_adv    = o_reg + CW'(NUM_COL);
            assign en[gi]   = live_reg && (o_reg <= idx_ext) && (idx_ext < win_end);
            assign last[gi] = en[gi] && (idx_ext == win_end - CW'(1));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    o_reg    <= CW'(gi);
                    live_reg <= 1'b0;
                end else if (flush) begin
                    o_reg    <= CW'(gi);
                    live_reg <= 1'b0;
                end else if (start_ok) begin
                    o_reg    <= CW'(gi);
                    live_reg <= (CW'(gi) <= lmk_in);
                end else if (xfer && last[gi]) begin
                    o_reg    <= o_adv;
                    live_reg <= (o_adv <= lmk_reg);
                end
            end
        end
    endgenerate

    // Only a busy column that this word would actually feed holds the stream.
    assign stall    = |(en & pe_busy);
    assign in_ready = (state_reg == STREAM) && !stall;
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok) state_next = STREAM;
            STREAM:  if (xfer && (in_idx_reg == l_reg - IDX_W'(1))) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            in_idx_reg     <= '0;
            l_reg          <= '0;
            k_reg          <= '0;
            lmk_reg        <= '0;
            x_valid_reg    <= 1'b0;
            x_data_reg     <= '0;
            x_col_en_reg   <= '0;
            x_col_last_reg <= '0;
            cfg_err_reg    <= 1'b0;
        end else if (flush) begin
            state_reg      <= IDLE;
            in_idx_reg     <= '0;
            l_reg          <= '0;
            k_reg          <= '0;
            lmk_reg        <= '0;
            x_valid_reg    <= 1'b0;
            x_data_reg     <= '0;
            x_col_en_reg   <= '0;
            x_col_last_reg <= '0;
            cfg_err_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cfg_err_reg <= (state_reg == IDLE) && start && !cfg_ok;
            if (start_ok) begin
                in_idx_reg <= '0;
                l_reg      <= row_len;
                k_reg      <= k_in;
                lmk_reg    <= lmk_in;
            end else if (xfer) begin
                in_idx_reg <= in_idx_reg + IDX_W'(1);
            end
            x_valid_reg    <= xfer;
            x_col_en_reg   <= xfer ? en : '0;
            x_col_last_reg <= xfer ? last : '0;
            if (xfer) x_data_reg <= in_data;
        end
    end

    assign x_valid    = x_valid_reg;
    assign x_data     = x_data_reg;
    assign x_col_en   = x_col_en_reg;
    assign x_col_last = x_col_last_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == DONE);
    assign cfg_err    = cfg_err_reg;

endmodule

// File: tb/tb_xbus_window_sched.sv
// Bench for xbus_window_sched: fixed vector tables, hand-written corner sequences
// and randomized rows checked against a window-assignment reference model.
module tb_xbus_window_sched;

    localparam int DW = 16;
    localparam int NC = 3;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    kernel_size = '0;
    logic [IW-1:0] row_len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [NC-1:0] pe_busy = '0;
    logic          x_valid;
    logic [DW-1:0] x_data;
    logic [NC-1:0] x_col_en;
    logic [NC-1:0] x_col_last;
    logic          busy;
    logic          done;
    logic          cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    xbus_window_sched #(.DATA_WIDTH(DW), .NUM_COL(NC), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start),
        .kernel_size(kernel_size), .row_len(row_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pe_busy(pe_busy), .x_valid(x_valid), .x_data(x_data),
        .x_col_en(x_col_en), .x_col_last(x_col_last),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       k;
        logic [7:0]       l;
        logic [5:0][2:0]  en;
        logic [5:0][2:0]  last;
    } vec_t;

    vec_t vecs [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: output o (0..L-K) lives on column o mod NC and reads words o..o+K-1.
    function automatic void win_mask(input int i, input int k, input int l,
                                     output logic [NC-1:0] m_en, output logic [NC-1:0] m_last);
        m_en = '0;
        m_last = '0;
        for (int o = 0; o <= l - k; o++) begin
            if (i >= o && i < o + k) begin
                m_en[o % NC] = 1'b1;
                if (i == o + k - 1) m_last[o % NC] = 1'b1;
            end
        end
    endfunction

    task automatic do_start(input int k, input int l);
        start = 1'b1;
        kernel_size = 8'(k);
        row_len = IW'(l);
        in_valid = 1'b0;
        pe_busy = '0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_fixed(input int v);
        int l;
        l = int'(vecs[v].l);
        do_start(int'(vecs[v].k), l);
        for (int j = 0; j <= l; j++) begin
            in_valid = (j < l);
            in_data = DW'(16'h100 + j);
            @(negedge clk);
            if (j < l) chk("fix_ready", in_ready, 1);
            if (j > 0) begin
                chk("fix_xvalid", x_valid, 1);
                chk("fix_en", x_col_en, vecs[v].en[j-1]);
                chk("fix_last", x_col_last, vecs[v].last[j-1]);
                chk("fix_data", x_data, 16'h100 + j - 1);
                chk("fix_done", done, (j == l));
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("fix_end_busy", busy, 0);
        chk("fix_end_xvalid", x_valid, 0);
        chk("fix_end_done", done, 0);
        @(posedge clk); #1;
    endtask

    // mode 0: random valid/pe_busy; 1: column 0 held busy 4 cycles on word 3; 2: start pulse at word 2
    task automatic run_row(input int k, input int l, input int mode);
        int phase, idx, cyc, low_ready, stall_n, dut_beats;
        logic          exp_xv, exp_ready;
        logic [DW-1:0] exp_xd;
        logic [NC-1:0] exp_en, exp_last, m_en, m_last;
        do_start(k, l);
        phase = 1; idx = 0; low_ready = 0; stall_n = 0; dut_beats = 0;
        exp_xv = 1'b0; exp_xd = '0; exp_en = '0; exp_last = '0;
        for (cyc = 0; cyc < 2000 && phase != 0; cyc++) begin
            in_data = DW'($urandom);
            start = 1'b0;
            case (mode)
                0: begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    pe_busy = NC'($urandom) & NC'($urandom);
                end
                1: begin
                    in_valid = 1'b1;
                    pe_busy = (phase == 1 && idx == 3 && stall_n < 4) ? NC'(1) : NC'(0);
                    if (pe_busy != 0) stall_n++;
                end
                default: begin
                    in_valid = 1'b1;
                    pe_busy = '0;
                    start = (phase == 1 && idx == 2);
                    kernel_size = 8'd1;
                    row_len = IW'(1);
                end
            endcase
            @(negedge clk);
            win_mask(idx, k, l, m_en, m_last);
            exp_ready = (phase == 1) && ((m_en & pe_busy) == 0);
            chk("row_ready", in_ready, exp_ready);
            chk("row_xvalid", x_valid, exp_xv);
            chk("row_en", x_col_en, exp_en);
            chk("row_last", x_col_last, exp_last);
            if (exp_xv) chk("row_data", x_data, exp_xd);
            chk("row_done", done, (phase == 2));
            chk("row_busy", busy, (phase != 0));
            chk("row_cfg_err", cfg_err, 0);
            if (x_valid) dut_beats++;
            if (phase == 1 && !in_ready) low_ready++;
            if (phase == 1 && in_valid && exp_ready) begin
                exp_xv = 1'b1; exp_xd = in_data; exp_en = m_en; exp_last = m_last;
                idx++;
                if (idx == l) phase = 2;
            end else begin
                exp_xv = 1'b0; exp_en = '0; exp_last = '0;
                if (phase == 2) phase = 0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        in_valid = 1'b0;
        pe_busy = '0;
        if (phase != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL row_timeout: phase %0d idx %0d required completion of L=%0d", phase, idx, l);
        end
        @(negedge clk);
        chk("row_end_busy", busy, 0);
        chk("row_end_xvalid", x_valid, 0);
        chk("row_beats", dut_beats, l);
        if (mode == 1) chk("row_stall_cycles", low_ready, 4);
        @(posedge clk); #1;
    endtask

    task automatic bad_start(input int k, input int l);
        do_start(k, l);
        @(negedge clk);
        chk("cfg_err_pulse", cfg_err, 1);
        chk("cfg_err_busy", busy, 0);
        chk("cfg_err_xvalid", x_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("cfg_err_clear", cfg_err, 0);
        chk("cfg_err_busy2", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0].k = 8'd3;
        vecs[0].l = 8'd5;
        vecs[0].en   = {3'b000, 3'b100, 3'b110, 3'b111, 3'b011, 3'b001};
        vecs[0].last = {3'b000, 3'b100, 3'b010, 3'b001, 3'b000, 3'b000};
        vecs[1].k = 8'd2;
        vecs[1].l = 8'd6;
        vecs[1].en   = {3'b010, 3'b011, 3'b101, 3'b110, 3'b011, 3'b001};
        vecs[1].last = {3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_xvalid", x_valid, 0);
        chk("rst_en", x_col_en, 0);
        chk("rst_last", x_col_last, 0);
        chk("rst_data", x_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 2; v++) run_fixed(v);

        run_row(2, 6, 1);

        bad_start(4, 8);
        bad_start(3, 2);

        // Flush mid-row with a coincident start that must be ignored.
        do_start(3, 8);
        in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        start = 1'b1;
        kernel_size = 8'd3;
        row_len = IW'(5);
        @(negedge clk);
        chk("flush_pre_xvalid", x_valid, 1);
        @(posedge clk); #1;
        flush = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_busy", busy, 0);
        chk("flush_xvalid", x_valid, 0);
        chk("flush_en", x_col_en, 0);
        chk("flush_cfg_err", cfg_err, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_start_ignored", busy, 0);
        @(posedge clk); #1;
        run_fixed(0);

        // Asynchronous reset between clock edges.
        do_start(3, 5);
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("arst_pre_xvalid", x_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_xvalid", x_valid, 0);
        chk("arst_en", x_col_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", in_ready, 0);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;

        run_row(3, 5, 2);

        for (int r = 0; r < 30; r++) begin
            int k, l;
            k = $urandom_range(0, 4);
            l = $urandom_range(0, 20);
            if (k >= 1 && k <= NC && k <= l) run_row(k, l, 0);
            else bad_start(k, l);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
